// File: rtl/pq_pkg.sv
// Shared types for the priority queue and its command scheduler.
// Key/value pair, sentinel values, command bundle and scheduler states.
package pq_pkg;

    localparam int KEY_W = 8;
    localparam int VAL_W = 8;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
    } kv_t;

    localparam logic [KEY_W-1:0] KEYINF = '1;
    localparam logic [VAL_W-1:0] VAL0 = '0;
    localparam kv_t KV_NULL = '{key: KEYINF, val: VAL0};

    // bit 0 = enqueue half, bit 1 = dequeue half; REPL sets both
    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_ENQ  = 2'b01,
        OP_DEQ  = 2'b10,
        OP_REPL = 2'b11
    } pq_op_t;

    typedef struct packed {
        pq_op_t op;
        kv_t    kv;
    } pq_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_STALL_BUSY,
        S_STALL_FULL,
        S_STALL_RESP
    } sched_state_t;

endpackage

// File: rtl/pq_cmd_sched_if.sv
// Client request/response handshake of the command scheduler.
// master = client side, slave = scheduler side.
interface pq_cmd_sched_if;
    import pq_pkg::*;

    logic   req_valid;
    logic   req_ready;
    pq_op_t req_op;
    kv_t    req_kv;
    logic   resp_valid;
    logic   resp_ready;
    kv_t    resp_kv;
    logic   resp_empty;

    modport master (
        output req_valid, req_op, req_kv, resp_ready,
        input  req_ready, resp_valid, resp_kv, resp_empty
    );

    modport slave (
        input  req_valid, req_op, req_kv, resp_ready,
        output req_ready, resp_valid, resp_kv, resp_empty
    );

endinterface

// File: rtl/pq_if.sv
// Device port of the register-array priority queue.
// The client issues enq/deq with kvi; the device reports kvo/full/empty/busy.
interface pq_if;
    import pq_pkg::*;

    kv_t  kvi;
    logic enq;
    logic deq;
    kv_t  kvo;
    logic full;
    logic empty;
    logic busy;

    modport client (
        output kvi, enq, deq,
        input  kvo, full, empty, busy
    );

    modport device (
        input  kvi, enq, deq,
        output kvo, full, empty, busy
    );

endinterface

// File: rtl/pq_cmd_fifo.sv
// Synchronous FIFO of scheduler commands with flush.
// Pointers carry one extra wrap bit so full/empty are exact.
module pq_cmd_fifo
    import pq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    flush,
    input  logic    push,
    input  pq_cmd_t din,
    input  logic    pop,
    output pq_cmd_t dout,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    pq_cmd_t     mem [DEPTH];

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + 1'b1;
            if (pop && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pq_cmd_sched.sv
// In-order command scheduler in front of the priority queue device port.
// Define PQ_SCHED_STATS_EN to add the saturating statistics counters.
module pq_cmd_sched
    import pq_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    pq_cmd_sched_if.slave cmd,
    pq_if.client          pq,
    output sched_state_t  state
`ifdef PQ_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_issued,
    output logic [CNT_W-1:0] stat_stall_full,
    output logic [CNT_W-1:0] stat_stall_resp
`endif
);

    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || CNT_W < 1)
    begin : g_bad_cfg
        $error("pq_cmd_sched: illegal CMD_DEPTH or CNT_W");
    end

    pq_cmd_t      head;
    logic         f_full;
    logic         f_empty;
    logic         push;
    logic         issue;
    logic         resp_free;
    logic         blk_full;
    logic         blk_resp;
    logic         resp_valid_q;
    kv_t          resp_kv_q;
    logic         resp_empty_q;
    sched_state_t state_q;
    sched_state_t state_d;

    assign push = cmd.req_valid && !f_full && (cmd.req_op != OP_NOP);

    pq_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .din   ('{op: cmd.req_op, kv: cmd.req_kv}),
        .pop   (issue),
        .dout  (head),
        .full  (f_full),
        .empty (f_empty)
    );

    // REPL keeps the occupancy constant, so only a plain ENQ waits on full
    assign resp_free = !resp_valid_q || cmd.resp_ready;
    assign blk_full  = (head.op == OP_ENQ) && pq.full;
    assign blk_resp  = head.op[1] && !resp_free;
    assign issue     = !f_empty && !pq.busy && !blk_full && !blk_resp &&
                       !rst && !flush;

    assign pq.enq = issue && head.op[0];
    assign pq.deq = issue && head.op[1];
    assign pq.kvi = pq.enq ? head.kv : KV_NULL;

    always_comb begin
        state_d = S_IDLE;
        if (f_empty)
            state_d = S_IDLE;
        else if (pq.busy)
            state_d = S_STALL_BUSY;
        else if (blk_full)
            state_d = S_STALL_FULL;
        else if (blk_resp)
            state_d = S_STALL_RESP;
        else
            state_d = S_READY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    assign state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_kv_q    <= KV_NULL;
            resp_empty_q <= 1'b0;
        end else if (pq.deq) begin
            resp_valid_q <= 1'b1;
            resp_kv_q    <= pq.empty ? KV_NULL : pq.kvo;
            resp_empty_q <= pq.empty;
        end else if (cmd.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign cmd.req_ready  = !f_full;
    assign cmd.resp_valid = resp_valid_q;
    assign cmd.resp_kv    = resp_kv_q;
    assign cmd.resp_empty = resp_empty_q;

`ifdef PQ_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued     <= '0;
            stat_stall_full <= '0;
            stat_stall_resp <= '0;
        end else begin
            if (issue && stat_issued != '1)
                stat_issued <= stat_issued + 1'b1;
            if (state_q == S_STALL_FULL && stat_stall_full != '1)
                stat_stall_full <= stat_stall_full + 1'b1;
            if (state_q == S_STALL_RESP && stat_stall_resp != '1)
                stat_stall_resp <= stat_stall_resp + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pq_cmd_sched.sv
// Scoreboard bench for pq_cmd_sched against a behavioural priority queue.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_pq_cmd_sched;
    import pq_pkg::*;

    localparam int PQ_CAP = 4;

    typedef struct {
        kv_t  kv;
        logic empty;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         side_deq;
    sched_state_t dut_state;

    int   checks = 0;
    int   errors = 0;
    int   issued = 0;
    int   cyc = 0;
    int   last_issue = 0;
    exp_t exp_q[$];

    pq_cmd_sched_if cmd ();
    pq_if           pq ();

`ifdef PQ_SCHED_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_stall_full;
    logic [15:0] stat_stall_resp;
`endif

    pq_cmd_sched #(.CMD_DEPTH(4), .CNT_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .cmd   (cmd),
        .pq    (pq),
        .state (dut_state)
`ifdef PQ_SCHED_STATS_EN
        ,
        .stat_issued     (stat_issued),
        .stat_stall_full (stat_stall_full),
        .stat_stall_resp (stat_stall_resp)
`endif
    );

    always #5 clk = ~clk;

    // behavioural queue: sorted ascending, busy for one cycle after any op
    kv_t  pqm[$];
    logic m_busy;
    int   m_cnt;
    kv_t  m_head;

    assign pq.busy  = m_busy;
    assign pq.full  = (m_cnt == PQ_CAP);
    assign pq.empty = (m_cnt == 0);
    assign pq.kvo   = m_head;

    function automatic int find_pos(input logic [7:0] k);
        for (int i = 0; i < pqm.size(); i++)
            if (pqm[i].key > k) return i;
        return pqm.size();
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pqm.delete();
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_head <= KV_NULL;
        end else begin
            if (pq.deq && pqm.size() > 0)
                void'(pqm.pop_front());
            if (pq.enq && (pq.deq || pqm.size() < PQ_CAP))
                pqm.insert(find_pos(pq.kvi.key), pq.kvi);
            if (side_deq && !pq.enq && !pq.deq && pqm.size() > 0)
                void'(pqm.pop_front());
            m_busy <= pq.enq || pq.deq || side_deq;
            m_cnt  <= pqm.size();
            m_head <= (pqm.size() > 0) ? pqm[0] : KV_NULL;
        end
    end

    // monitor: issue legality and response scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (pq.enq || pq.deq) begin
                checks++;
                if ((issued > 0 && cyc - last_issue < 2) || pq.busy ||
                    (pq.enq && !pq.deq && pq.full)) begin
                    errors++;
                    $display("FAIL issue_gate: cyc %0d gap %0d busy %0b full %0b, required gap>=2 busy 0",
                             cyc, cyc - last_issue, pq.busy, pq.full);
                end
                issued++;
                last_issue = cyc;
            end
            if (cmd.resp_valid && cmd.resp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got key %0h val %0h empty %0b, required none",
                             cmd.resp_kv.key, cmd.resp_kv.val, cmd.resp_empty);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({cmd.resp_kv, cmd.resp_empty} !== {e.kv, e.empty}) begin
                        errors++;
                        $display("FAIL resp: got key %0h val %0h empty %0b, required key %0h val %0h empty %0b",
                                 cmd.resp_kv.key, cmd.resp_kv.val, cmd.resp_empty,
                                 e.kv.key, e.kv.val, e.empty);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input logic [7:0] k, input logic [7:0] v,
                               input logic e);
        exp_t x;
        x.kv    = '{key: k, val: v};
        x.empty = e;
        exp_q.push_back(x);
    endtask

    task automatic send(input pq_op_t op, input logic [7:0] k,
                        input logic [7:0] v);
        int n;
        @(posedge clk); #1;
        cmd.req_valid = 1'b1;
        cmd.req_op    = op;
        cmd.req_kv    = '{key: k, val: v};
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd.req_ready && n < 200);
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: req_ready low for %0d cycles, required high", n);
        end
        @(posedge clk); #1;
        cmd.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dut_state == S_IDLE && !pq.busy) && n < 300);
        chk("wait_idle_timeout", 32'(n >= 300), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued_before;
`ifdef PQ_SCHED_STATS_EN
        logic [15:0] stat_before;
`endif
        rst            = 1'b1;
        flush          = 1'b0;
        side_deq       = 1'b0;
        cmd.req_valid  = 1'b0;
        cmd.req_op     = OP_NOP;
        cmd.req_kv     = KV_NULL;
        cmd.resp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(cmd.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(cmd.resp_valid), 32'd0);
        chk("rst_resp_kv", 32'(cmd.resp_kv), 32'h0000FF00);
        chk("rst_resp_empty", 32'(cmd.resp_empty), 32'd0);
        chk("rst_pq_enq", 32'(pq.enq), 32'd0);
        chk("rst_pq_deq", 32'(pq.deq), 32'd0);
        chk("rst_pq_kvi", 32'(pq.kvi), 32'h0000FF00);
        chk("rst_state", 32'(dut_state), 32'(S_IDLE));
`ifdef PQ_SCHED_STATS_EN
        chk("rst_stat_issued", 32'(stat_issued), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        // ordering: 7,3,9 in, 3,7,9 out; the NOP is dropped
        send(OP_ENQ, 8'd7, 8'h17);
        send(OP_ENQ, 8'd3, 8'h13);
        send(OP_NOP, 8'd1, 8'h11);
        send(OP_ENQ, 8'd9, 8'h19);
        expect_resp(8'd3, 8'h13, 1'b0);
        send(OP_DEQ, 8'd0, 8'h00);
        expect_resp(8'd7, 8'h17, 1'b0);
        send(OP_DEQ, 8'd0, 8'h00);
        expect_resp(8'd9, 8'h19, 1'b0);
        send(OP_DEQ, 8'd0, 8'h00);
        wait_idle();

        // dequeue from an empty queue
        expect_resp(8'hFF, 8'h00, 1'b1);
        send(OP_DEQ, 8'd0, 8'h00);
        wait_idle();
        chk("empty_deq_queue_empty", 32'(pq.empty), 32'd1);

        // fill to capacity, then ENQ 1 stalls with a DEQ behind it
        send(OP_ENQ, 8'd10, 8'hA0);
        send(OP_ENQ, 8'd20, 8'hB0);
        send(OP_ENQ, 8'd30, 8'hC0);
        send(OP_ENQ, 8'd40, 8'hD0);
        wait_idle();
        chk("fill_full", 32'(pq.full), 32'd1);
        send(OP_ENQ, 8'd1, 8'h01);
        expect_resp(8'd1, 8'h01, 1'b0);
        send(OP_DEQ, 8'd0, 8'h00);
        repeat (4) @(negedge clk);
        chk("stall_full_state", 32'(dut_state), 32'(S_STALL_FULL));
        chk("stall_full_enq_low", 32'(pq.enq), 32'd0);
        chk("stall_full_no_bypass", 32'(cmd.resp_valid), 32'd0);
`ifdef PQ_SCHED_STATS_EN
        chk("stat_stall_full_nz", 32'(stat_stall_full != 0), 32'd1);
`endif
        @(posedge clk); #1;
        side_deq = 1'b1;
        @(posedge clk); #1;
        side_deq = 1'b0;
        wait_idle();
        expect_resp(8'd20, 8'hB0, 1'b0);
        send(OP_DEQ, 8'd0, 8'h00);
        expect_resp(8'd30, 8'hC0, 1'b0);
        send(OP_DEQ, 8'd0, 8'h00);
        expect_resp(8'd40, 8'hD0, 1'b0);
        send(OP_DEQ, 8'd0, 8'h00);
        wait_idle();

        // response back-pressure
        send(OP_ENQ, 8'd50, 8'h50);
        send(OP_ENQ, 8'd60, 8'h60);
        wait_idle();
        cmd.resp_ready = 1'b0;
        expect_resp(8'd50, 8'h50, 1'b0);
        send(OP_DEQ, 8'd0, 8'h00);
        expect_resp(8'd60, 8'h60, 1'b0);
        send(OP_DEQ, 8'd0, 8'h00);
        repeat (6) @(negedge clk);
        chk("stall_resp_state", 32'(dut_state), 32'(S_STALL_RESP));
        chk("stall_resp_held_valid", 32'(cmd.resp_valid), 32'd1);
        chk("stall_resp_held_key", 32'(cmd.resp_kv.key), 32'd50);
        chk("stall_resp_deq_low", 32'(pq.deq), 32'd0);
`ifdef PQ_SCHED_STATS_EN
        chk("stat_stall_resp_nz", 32'(stat_stall_resp != 0), 32'd1);
`endif
        @(posedge clk); #1;
        cmd.resp_ready = 1'b1;
        @(negedge clk);
        chk("drain_edge_issue", 32'(pq.deq), 32'd1);
        wait_idle();

        // replace: 5 out, 2 stays
        send(OP_ENQ, 8'd5, 8'h55);
        wait_idle();
        expect_resp(8'd5, 8'h55, 1'b0);
        send(OP_REPL, 8'd2, 8'h22);
        expect_resp(8'd2, 8'h22, 1'b0);
        send(OP_DEQ, 8'd0, 8'h00);
        wait_idle();

        // flush four queued commands behind a held response
        cmd.resp_ready = 1'b0;
        expect_resp(8'hFF, 8'h00, 1'b1);
        send(OP_DEQ, 8'd0, 8'h00);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++)
            send(OP_DEQ, 8'd0, 8'h00);
        @(negedge clk);
        chk("flush_pre_fifo_full", 32'(cmd.req_ready), 32'd0);
        issued_before = issued;
`ifdef PQ_SCHED_STATS_EN
        stat_before = stat_issued;
`endif
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (8) @(negedge clk);
        chk("flush_req_ready", 32'(cmd.req_ready), 32'd1);
        chk("flush_state_idle", 32'(dut_state), 32'(S_IDLE));
        chk("flush_resp_kept", 32'(cmd.resp_valid), 32'd1);
        @(posedge clk); #1;
        cmd.resp_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("flush_no_issue", 32'(issued - issued_before), 32'd0);
`ifdef PQ_SCHED_STATS_EN
        chk("flush_stat_issued", 32'(stat_issued), 32'(stat_before));
        chk("stat_issued_total", 32'(stat_issued), 32'd24);
`endif
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("issue_total", 32'(issued), 32'd24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
